// File: rtl/vga_colorizer_if.sv
// Read-port bundle between the colorizer and its world-map RAM / icon ROM.
// Both memories return data two clocks after the address is registered.
interface vga_colorizer_if;
    logic [13:0] world_addr;
    logic [1:0]  world_pixel;
    logic [7:0]  icon_addr;
    logic [1:0]  icon_pixel;

    modport master (
        output world_addr,
        output icon_addr,
        input  world_pixel,
        input  icon_pixel
    );

    modport slave (
        input  world_addr,
        input  icon_addr,
        output world_pixel,
        output icon_pixel
    );
endinterface

// File: rtl/vga_colorizer.sv
// Pixel colorizer: maps the 512x480 active area onto a 128x120 world map of 4x4 cells,
// overlays a 16x16 icon sprite and emits 12-bit RGB with syncs kept aligned.
module vga_colorizer #(
    parameter int PIPE_LAT = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    video_on_in,
    input  logic [9:0]              pixel_row,
    input  logic [9:0]              pixel_column,
    input  logic [6:0]              icon_x,
    input  logic [6:0]              icon_y,
    vga_colorizer_if.master         mem,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    video_on_out,
    output logic [11:0]             rgb,
    output logic                    frame_tick
);

    // Intermediate delay-line depth: S1..S3 feed the S4 output register.
    localparam int DLY = PIPE_LAT - 1;

    function automatic logic [11:0] world_color(input logic [1:0] code);
        case (code)
            2'b00:   world_color = 12'hFFF;
            2'b01:   world_color = 12'h000;
            2'b10:   world_color = 12'hF00;
            2'b11:   world_color = 12'h00F;
            default: world_color = 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] icon_color(input logic [1:0] code);
        case (code)
            2'b01:   icon_color = 12'h0F0;
            2'b10:   icon_color = 12'hFF0;
            2'b11:   icon_color = 12'hF0F;
            default: icon_color = 12'h000;
        endcase
    endfunction

    logic [6:0]     ix_r;
    logic [6:0]     iy_r;
    logic           vsync_prev_r;
    logic [13:0]    world_addr_r;
    logic [7:0]     icon_addr_r;
    logic [DLY-1:0] hsync_pipe_r;
    logic [DLY-1:0] vsync_pipe_r;
    logic [DLY-1:0] video_pipe_r;
    logic [DLY-1:0] hit_pipe_r;

    logic [10:0]    col_ext_s;
    logic [10:0]    row_ext_s;
    logic [10:0]    ix_base_s;
    logic [10:0]    iy_base_s;
    logic [3:0]     dx_s;
    logic [3:0]     dy_s;
    logic           hit_s;
    logic [7:0]     icon_addr_s;
    logic           vsync_fall_s;
    logic [11:0]    rgb_s;

    assign mem.world_addr = world_addr_r;
    assign mem.icon_addr  = icon_addr_r;

    // S1 icon hit test in 11-bit space so positions past the screen edge never wrap.
    always_comb begin
        col_ext_s   = {1'b0, pixel_column};
        row_ext_s   = {1'b0, pixel_row};
        ix_base_s   = {2'b00, ix_r, 2'b00};
        iy_base_s   = {2'b00, iy_r, 2'b00};
        dx_s        = pixel_column[3:0] - {ix_r[1:0], 2'b00};
        dy_s        = pixel_row[3:0] - {iy_r[1:0], 2'b00};
        hit_s       = (col_ext_s >= ix_base_s) && (col_ext_s < (ix_base_s + 11'd16)) &&
                      (row_ext_s >= iy_base_s) && (row_ext_s < (iy_base_s + 11'd16));
        icon_addr_s = 8'h00;
        if (hit_s) begin
            icon_addr_s = {dy_s, dx_s};
        end else begin
            icon_addr_s = 8'h00;
        end
        vsync_fall_s = vsync_prev_r & ~vsync_in;
    end

    // S4 colour select: blanking forces black, opaque icon pixels win over the world.
    always_comb begin
        rgb_s = 12'h000;
        if (!video_pipe_r[DLY-1]) begin
            rgb_s = 12'h000;
        end else if (hit_pipe_r[DLY-1] && (mem.icon_pixel != 2'b00)) begin
            rgb_s = icon_color(mem.icon_pixel);
        end else begin
            rgb_s = world_color(mem.world_pixel);
        end
    end

    // Position latch and frame tick: icon moves only at the vsync falling edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            ix_r         <= 7'd0;
            iy_r         <= 7'd0;
            vsync_prev_r <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            vsync_prev_r <= vsync_in;
            frame_tick   <= vsync_fall_s;
            if (vsync_fall_s) begin
                ix_r <= icon_x;
                iy_r <= icon_y;
            end
        end
    end

    // S1 address registers plus the delay line covering memory latency.
    always_ff @(posedge clock) begin
        if (rst) begin
            world_addr_r <= 14'd0;
            icon_addr_r  <= 8'h00;
            hsync_pipe_r <= {DLY{1'b1}};
            vsync_pipe_r <= {DLY{1'b1}};
            video_pipe_r <= {DLY{1'b0}};
            hit_pipe_r   <= {DLY{1'b0}};
        end else begin
            world_addr_r <= {pixel_row[8:2], pixel_column[8:2]};
            icon_addr_r  <= icon_addr_s;
            hsync_pipe_r <= {hsync_pipe_r[DLY-2:0], hsync_in};
            vsync_pipe_r <= {vsync_pipe_r[DLY-2:0], vsync_in};
            video_pipe_r <= {video_pipe_r[DLY-2:0], video_on_in};
            hit_pipe_r   <= {hit_pipe_r[DLY-2:0], hit_s};
        end
    end

    // S4 output register.
    always_ff @(posedge clock) begin
        if (rst) begin
            rgb          <= 12'h000;
            hsync_out    <= 1'b1;
            vsync_out    <= 1'b1;
            video_on_out <= 1'b0;
        end else begin
            rgb          <= rgb_s;
            hsync_out    <= hsync_pipe_r[DLY-1];
            vsync_out    <= vsync_pipe_r[DLY-1];
            video_on_out <= video_pipe_r[DLY-1];
        end
    end

endmodule

// File: tb/tb_vga_colorizer.sv
// Directed bench for vga_colorizer with a two-clock memory model behind the interface.
module tb_vga_colorizer;

    logic        clock;
    logic        rst;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on_in;
    logic [9:0]  pixel_row;
    logic [9:0]  pixel_column;
    logic [6:0]  icon_x;
    logic [6:0]  icon_y;
    logic        hsync_out;
    logic        vsync_out;
    logic        video_on_out;
    logic [11:0] rgb;
    logic        frame_tick;

    int n_cmp;
    int n_fail;

    logic [1:0] world_mem [16384];
    logic [1:0] icon_rom  [256];
    logic [1:0] world_q;
    logic [1:0] icon_q;

    vga_colorizer_if bus ();

    vga_colorizer #(.PIPE_LAT(4)) dut (
        .clock        (clock),
        .rst          (rst),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .video_on_in  (video_on_in),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .icon_x       (icon_x),
        .icon_y       (icon_y),
        .mem          (bus),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out),
        .rgb          (rgb),
        .frame_tick   (frame_tick)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    // Memories: address registered in the DUT, then two more register stages.
    always @(posedge clock) begin
        world_q         <= world_mem[bus.world_addr];
        icon_q          <= icon_rom[bus.icon_addr];
        bus.world_pixel <= world_q;
        bus.icon_pixel  <= icon_q;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_pixel(input int row, input int col, input logic von);
        pixel_row    = 10'(row);
        pixel_column = 10'(col);
        video_on_in  = von;
    endtask

    task automatic test_reset;
        set_pixel(200, 100, 1'b1);
        hsync_in = 1'b0;
        tick(5);
        n_cmp++;
        if (rgb !== 12'hF00) begin n_fail++; $display("FAIL pre_reset_rgb got %h want %h", rgb, 12'hF00); end
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if ({rgb, hsync_out, vsync_out, video_on_out, bus.world_addr, bus.icon_addr, frame_tick} !==
            {12'h000, 1'b1, 1'b1, 1'b0, 14'd0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got rgb=%h hs=%b vs=%b von=%b wa=%0d ia=%h ft=%b",
                     rgb, hsync_out, vsync_out, video_on_out, bus.world_addr, bus.icon_addr, frame_tick);
        end
        rst = 1'b0;
        vsync_in = 1'b0;
        tick(1);
        n_cmp++;
        if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL first_cycle_tick got %b want 1", frame_tick); end
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if ({rgb, hsync_out, vsync_out, video_on_out} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold%0d got rgb=%h hs=%b vs=%b von=%b", k, rgb, hsync_out, vsync_out, video_on_out);
            end
            if (k < 3) tick(1);
        end
        tick(1);
        n_cmp++;
        if ({rgb, hsync_out, vsync_out, video_on_out} !== {12'hF00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_release got rgb=%h hs=%b vs=%b von=%b want f00 0 0 1", rgb, hsync_out, vsync_out, video_on_out);
        end
        vsync_in = 1'b1;
        hsync_in = 1'b1;
    endtask

    task automatic test_address_map;
        set_pixel(0, 0, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.world_addr !== 14'd0) begin n_fail++; $display("FAIL addr_origin got %0d want 0", bus.world_addr); end
        tick(3);
        n_cmp++;
        if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL rgb_origin got %h want fff", rgb); end
        set_pixel(200, 100, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.world_addr !== 14'd6425) begin n_fail++; $display("FAIL addr_200_100 got %0d want 6425", bus.world_addr); end
        tick(3);
        n_cmp++;
        if ({rgb, video_on_out} !== {12'hF00, 1'b1}) begin
            n_fail++; $display("FAIL rgb_200_100 got %h von=%b want f00 1", rgb, video_on_out);
        end
    endtask

    task automatic test_icon_overlay;
        set_pixel(22, 43, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h23) begin n_fail++; $display("FAIL icon_addr_22_43 got %h want 23", bus.icon_addr); end
        tick(3);
        n_cmp++;
        if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL icon_01 got %h want 0f0", rgb); end
        set_pixel(22, 44, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL icon_transparent got %h want fff", rgb); end
        set_pixel(22, 45, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'hFF0) begin n_fail++; $display("FAIL icon_10 got %h want ff0", rgb); end
        set_pixel(22, 46, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'hF0F) begin n_fail++; $display("FAIL icon_11 got %h want f0f", rgb); end
        set_pixel(22, 56, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h00) begin n_fail++; $display("FAIL icon_right_edge got %h want 00", bus.icon_addr); end
        set_pixel(19, 43, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h00) begin n_fail++; $display("FAIL icon_top_edge got %h want 00", bus.icon_addr); end
        tick(3);
    endtask

    task automatic test_tear_free;
        int pulses;
        icon_x = 7'd20;
        set_pixel(22, 43, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL midframe_old_pos got %h want 0f0", rgb); end
        set_pixel(22, 83, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL midframe_new_pos got %h want fff", rgb); end
        pulses = 0;
        vsync_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            if (frame_tick === 1'b1) pulses++;
        end
        vsync_in = 1'b1;
        tick(2);
        n_cmp++;
        if (pulses !== 1) begin n_fail++; $display("FAIL frame_tick_pulses got %0d want 1", pulses); end
        set_pixel(22, 83, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL next_frame_new_pos got %h want 0f0", rgb); end
        set_pixel(22, 43, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL next_frame_old_pos got %h want fff", rgb); end
        // latch and pixel in the same cycle: old position still applies
        icon_x = 7'd30;
        vsync_in = 1'b0;
        set_pixel(22, 83, 1'b1);
        tick(1);
        n_cmp++;
        if ({bus.icon_addr, frame_tick} !== {8'h23, 1'b1}) begin
            n_fail++; $display("FAIL same_cycle_latch got ia=%h ft=%b want 23 1", bus.icon_addr, frame_tick);
        end
        vsync_in = 1'b1;
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h00) begin n_fail++; $display("FAIL after_latch_old got %h want 00", bus.icon_addr); end
        set_pixel(22, 123, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h23) begin n_fail++; $display("FAIL after_latch_new got %h want 23", bus.icon_addr); end
        tick(3);
    endtask

    task automatic test_clipping;
        icon_x = 7'd127;
        vsync_in = 1'b0;
        tick(1);
        vsync_in = 1'b1;
        set_pixel(22, 508, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h20) begin n_fail++; $display("FAIL clip_508_addr got %h want 20", bus.icon_addr); end
        tick(3);
        n_cmp++;
        if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL clip_508_rgb got %h want 0f0", rgb); end
        set_pixel(22, 511, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL clip_511_rgb got %h want 0f0", rgb); end
        set_pixel(22, 512, 1'b0);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h24) begin n_fail++; $display("FAIL clip_512_addr got %h want 24", bus.icon_addr); end
        tick(3);
        n_cmp++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL clip_512_rgb got %h want 000", rgb); end
        set_pixel(23, 0, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h00) begin n_fail++; $display("FAIL clip_nowrap_addr got %h want 00", bus.icon_addr); end
        tick(3);
        n_cmp++;
        if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL clip_nowrap_rgb got %h want fff", rgb); end
        icon_x = 7'd10;
        icon_y = 7'd120;
        vsync_in = 1'b0;
        tick(1);
        vsync_in = 1'b1;
        set_pixel(479, 43, 1'b1);
        tick(1);
        n_cmp++;
        if (bus.icon_addr !== 8'h00) begin n_fail++; $display("FAIL iy120_addr got %h want 00", bus.icon_addr); end
        tick(3);
        n_cmp++;
        if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL iy120_rgb got %h want fff", rgb); end
    endtask

    task automatic test_blanking_and_palette;
        set_pixel(22, 600, 1'b0);
        tick(1);
        n_cmp++;
        if (bus.world_addr !== 14'd662) begin n_fail++; $display("FAIL blank_addr got %0d want 662", bus.world_addr); end
        tick(3);
        n_cmp++;
        if ({rgb, video_on_out} !== {12'h000, 1'b0}) begin
            n_fail++; $display("FAIL blank_rgb got %h von=%b want 000 0", rgb, video_on_out);
        end
        set_pixel(200, 104, 1'b1);
        tick(4);
        n_cmp++;
        if (rgb !== 12'h00F) begin n_fail++; $display("FAIL world_11 got %h want 00f", rgb); end
        set_pixel(200, 108, 1'b1);
        tick(4);
        n_cmp++;
        if ({rgb, video_on_out} !== {12'h000, 1'b1}) begin
            n_fail++; $display("FAIL world_01 got %h von=%b want 000 1", rgb, video_on_out);
        end
    endtask

    task automatic test_back_to_back;
        set_pixel(200, 104, 1'b1);
        tick(6);
        set_pixel(200, 100, 1'b1);
        tick(3);
        n_cmp++;
        if (rgb !== 12'h00F) begin n_fail++; $display("FAIL latency_early got %h want 00f", rgb); end
        tick(1);
        n_cmp++;
        if (rgb !== 12'hF00) begin n_fail++; $display("FAIL latency_edge4 got %h want f00", rgb); end
    endtask

    task automatic test_hsync_alignment;
        logic exp_hs;
        int   c_old;
        for (int j = 0; j < 200; j++) begin
            set_pixel(22, 600 + j, 1'b0);
            hsync_in = ((600 + j) >= 659 && (600 + j) <= 755) ? 1'b0 : 1'b1;
            tick(1);
            if (j >= 3) begin
                c_old  = 600 + j - 3;
                exp_hs = (c_old >= 659 && c_old <= 755) ? 1'b0 : 1'b1;
                n_cmp++;
                if ({hsync_out, vsync_out, video_on_out} !== {exp_hs, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL hsync_col%0d got hs=%b vs=%b von=%b want hs=%b", c_old, hsync_out, vsync_out, video_on_out, exp_hs);
                end
            end
        end
        hsync_in = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int a = 0; a < 16384; a++) world_mem[a] = 2'b00;
        for (int a = 0; a < 256; a++) icon_rom[a] = 2'b00;
        world_mem[6425] = 2'b10;
        world_mem[6426] = 2'b11;
        world_mem[6427] = 2'b01;
        world_mem[662]  = 2'b11;
        icon_rom[8'h20] = 2'b01;
        icon_rom[8'h23] = 2'b01;
        icon_rom[8'h24] = 2'b00;
        icon_rom[8'h25] = 2'b10;
        icon_rom[8'h26] = 2'b11;
        rst = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        icon_x = 7'd10;
        icon_y = 7'd5;
        set_pixel(0, 0, 1'b0);
        tick(2);
        rst = 1'b0;
        test_reset;
        test_address_map;
        test_icon_overlay;
        test_tear_free;
        test_clipping;
        test_blanking_and_palette;
        test_back_to_back;
        test_hsync_alignment;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
